// File: rtl/ula_seq.sv
// ula_seq: sequential ALU; single-cycle logic/arith ops, iterative shift-add MUL and restoring DIV.
// Define ULA_SEQ_MOD_EN to decode opcode 14 as MOD through the shared divider.
module ula_seq #(
  parameter int DATA_SIZE = 11
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [3:0]           opcode,
  input  logic [DATA_SIZE-1:0] operand_a,
  input  logic [DATA_SIZE-1:0] operand_b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATA_SIZE-1:0] out,
  output logic                 error
);
  localparam int W = DATA_SIZE;
  localparam int CW = $clog2(W);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state_q, state_d;
  logic [W-1:0] out_q, out_d, a_q, a_d, b_q, b_d, acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic err_q, err_d, div_q, div_d;
`ifdef ULA_SEQ_MOD_EN
  logic mod_q, mod_d;
`endif
  logic [W-1:0] alu, acc_mul, a_div, acc_div;
  logic [W:0] rsh;
  logic alu_err, multi, ge;
  always_comb begin
    alu = '0;
    alu_err = 1'b0;
    multi = 1'b0;
    case (opcode)
      4'd4: alu = operand_a + operand_b;
      4'd5: alu = operand_a - operand_b;
      4'd6: multi = 1'b1;
      4'd7: begin
        alu = operand_b == '0 ? '1 : '0;
        alu_err = operand_b == '0;
        multi = operand_b != '0;
      end
      4'd8: alu = operand_a & operand_b;
      4'd9: alu = W'(~|(operand_a & operand_b));
      4'd10: alu = operand_a | operand_b;
      4'd11: alu = operand_a ^ operand_b;
      4'd12: alu = operand_a > operand_b ? W'(1) : operand_a == operand_b ? '0 : '1;
      4'd13: alu = W'(~|operand_a);
`ifdef ULA_SEQ_MOD_EN
      4'd14: begin
        alu = operand_b == '0 ? operand_a : '0;
        alu_err = operand_b == '0;
        multi = operand_b != '0;
      end
`endif
      default: alu_err = 1'b1;
    endcase
  end
  // One iteration step: MUL adds the shifted multiplicand; DIV shifts the next dividend bit into the remainder.
  assign acc_mul = acc_q + (b_q[0] ? a_q : '0);
  assign rsh = {acc_q, a_q[W-1]};
  assign ge = rsh >= {1'b0, b_q};
  assign acc_div = ge ? W'(rsh - {1'b0, b_q}) : rsh[W-1:0];
  assign a_div = {a_q[W-2:0], ge};
  always_comb begin
    state_d = state_q;
    out_d = out_q;
    err_d = err_q;
    a_d = a_q;
    b_d = b_q;
    acc_d = acc_q;
    cnt_d = cnt_q;
    div_d = div_q;
`ifdef ULA_SEQ_MOD_EN
    mod_d = mod_q;
`endif
    case (state_q)
      IDLE: if (in_valid) begin
        a_d = operand_a;
        b_d = operand_b;
        acc_d = '0;
        cnt_d = '0;
        div_d = opcode != 4'd6;
`ifdef ULA_SEQ_MOD_EN
        mod_d = opcode == 4'd14;
`endif
        err_d = alu_err;
        state_d = multi ? CALC : DONE;
        out_d = multi ? out_q : alu;
      end
      CALC: begin
        cnt_d = cnt_q + 1'b1;
        acc_d = div_q ? acc_div : acc_mul;
        a_d = div_q ? a_div : a_q << 1;
        b_d = div_q ? b_q : b_q >> 1;
        if (cnt_q == CW'(W - 1)) begin
          state_d = DONE;
`ifdef ULA_SEQ_MOD_EN
          out_d = div_q ? (mod_q ? acc_div : a_div) : acc_mul;
`else
          out_d = div_q ? a_div : acc_mul;
`endif
        end
      end
      DONE: state_d = out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      out_q <= '0;
      err_q <= 1'b0;
      a_q <= '0;
      b_q <= '0;
      acc_q <= '0;
      cnt_q <= '0;
      div_q <= 1'b0;
`ifdef ULA_SEQ_MOD_EN
      mod_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      out_q <= out_d;
      err_q <= err_d;
      a_q <= a_d;
      b_q <= b_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      div_q <= div_d;
`ifdef ULA_SEQ_MOD_EN
      mod_q <= mod_d;
`endif
    end
  end
  assign in_ready = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign out = out_q;
  assign error = err_q;
endmodule

// File: tb/tb_ula_seq.sv
// tb_ula_seq: directed vector table plus hand sequences for DONE hold and mid-CALC reset.
module tb_ula_seq;
  localparam int W = 11;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [3:0] opcode = '0;
  logic [W-1:0] operand_a = '0, operand_b = '0;
  logic out_valid;
  logic out_ready = 1'b1;
  logic [W-1:0] out;
  logic error;
  int tests = 0, fails = 0;
  typedef struct {
    logic [3:0] op;
    logic [W-1:0] a, b, exp_out;
    logic exp_err;
    int exp_lat;
  } vec_t;
  vec_t vecs[$];

  ula_seq #(.DATA_SIZE(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .operand_a(operand_a), .operand_b(operand_b),
    .out_valid(out_valid), .out_ready(out_ready), .out(out), .error(error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic run(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                     output logic [W-1:0] o, output logic e, output int lat, output bit rdy_lo);
    @(negedge clk);
    in_valid = 1'b1;
    opcode = op;
    operand_a = a;
    operand_b = b;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 1;
    rdy_lo = 1'b1;
    while (!out_valid && lat < 40) begin
      if (in_ready) rdy_lo = 1'b0;
      @(posedge clk);
      #1 lat++;
    end
    o = out;
    e = error;
    if (out_ready) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic vec_t mk(logic [3:0] op, int a, int b, int o, logic e, int lat);
    vec_t v;
    v.op = op;
    v.a = W'(a);
    v.b = W'(b);
    v.exp_out = W'(o);
    v.exp_err = e;
    v.exp_lat = lat;
    return v;
  endfunction

  initial begin
    logic [W-1:0] o;
    logic e;
    int lat;
    bit rdy_lo;
    vecs.push_back(mk(4, 10, 20, 30, 0, 1));
    vecs.push_back(mk(5, 5, 10, 2043, 0, 1));
    vecs.push_back(mk(6, 24, 25, 600, 0, 12));
    vecs.push_back(mk(7, 13, 5, 2, 0, 12));
    vecs.push_back(mk(12, 123, 122, 1, 0, 1));
    vecs.push_back(mk(12, 123, 124, 2047, 0, 1));
    vecs.push_back(mk(12, 123, 123, 0, 0, 1));
    vecs.push_back(mk(9, 'h55, 'hAA, 1, 0, 1));
    vecs.push_back(mk(9, 'h0F, 'h3C, 0, 0, 1));
    vecs.push_back(mk(13, 123, 0, 0, 0, 1));
    vecs.push_back(mk(13, 0, 7, 1, 0, 1));
    vecs.push_back(mk(10, 'h55, 'hAA, 'hFF, 0, 1));
    vecs.push_back(mk(11, 'h0F, 'hFF, 'hF0, 0, 1));
    vecs.push_back(mk(8, 'h0F, 'h3C, 'h0C, 0, 1));
    vecs.push_back(mk(7, 7, 0, 2047, 1, 1));
    vecs.push_back(mk(2, 7, 3, 0, 1, 1));
    vecs.push_back(mk(15, 7, 3, 0, 1, 1));
    vecs.push_back(mk(4, 2047, 1, 0, 0, 1));
    vecs.push_back(mk(6, 2047, 2047, 1, 0, 12));
    vecs.push_back(mk(7, 2047, 1, 2047, 0, 12));
    vecs.push_back(mk(7, 5, 13, 0, 0, 12));
`ifdef ULA_SEQ_MOD_EN
    vecs.push_back(mk(14, 13, 5, 3, 0, 12));
    vecs.push_back(mk(14, 7, 0, 7, 1, 1));
`else
    vecs.push_back(mk(14, 13, 5, 0, 1, 1));
`endif
    #2;
    chk("reset out_valid", out_valid, 0);
    chk("reset out", out, 0);
    chk("reset error", error, 0);
    chk("reset in_ready", in_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1 chk("in_ready after reset", in_ready, 1);
    foreach (vecs[i]) begin
      run(vecs[i].op, vecs[i].a, vecs[i].b, o, e, lat, rdy_lo);
      chk($sformatf("v%0d op%0d out", i, vecs[i].op), o, vecs[i].exp_out);
      chk($sformatf("v%0d op%0d error", i, vecs[i].op), e, vecs[i].exp_err);
      chk($sformatf("v%0d op%0d latency", i, vecs[i].op), lat, vecs[i].exp_lat);
      if (vecs[i].exp_lat > 1) chk($sformatf("v%0d in_ready low in CALC", i), rdy_lo, 1);
    end
    // DONE held with out_ready low while a competing request is presented
    out_ready = 1'b0;
    run(4, 1, 2, o, e, lat, rdy_lo);
    chk("hold first out", o, 3);
    @(negedge clk);
    in_valid = 1'b1;
    opcode = 4'd4;
    operand_a = 100;
    operand_b = 100;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("hold c%0d out", k), out, 3);
      chk($sformatf("hold c%0d out_valid", k), out_valid, 1);
      chk($sformatf("hold c%0d in_ready", k), in_ready, 0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("release out_valid", out_valid, 0);
    chk("release in_ready", in_ready, 1);
    in_valid = 1'b0;
    @(posedge clk);
    #1 chk("ignored request not taken", in_ready, 1);
    // reset during CALC cycle 4 of a MUL
    @(negedge clk);
    in_valid = 1'b1;
    opcode = 4'd6;
    operand_a = 24;
    operand_b = 25;
    @(posedge clk);
    #1 in_valid = 1'b0;
    chk("mul in CALC", in_ready, 0);
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("abort out_valid", out_valid, 0);
    chk("abort out", out, 0);
    chk("abort error", error, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1 chk("abort in_ready after release", in_ready, 1);
    lat = 0;
    for (int k = 0; k < 15; k++) begin
      @(posedge clk);
      #1 if (out_valid) lat++;
    end
    chk("no stale result", lat, 0);
    run(4, 100, 23, o, e, lat, rdy_lo);
    chk("post-abort add out", o, 123);
    chk("post-abort add latency", lat, 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
